mem_port_arbiter: RTL

//  Shares one single-ported instruction/data memory between two requesters:
//  - the fetch stage (IF)
//  - the load/store stage (DM), driven by decode mem_read/mem_write/mem_size.

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-macro signals around the shared memory port.
// The arbiter takes the master view; the pipeline/memory environment takes the slave view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [1:0]        dm_size;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [1:0]        mem_size;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport master (
      input  if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_size, mem_addr, mem_wdata, busy
   );

   modport slave (
      output if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_size, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and load/store (DM).
// DM has priority; IF is forced through after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1,
   parameter int STARVE_MAX  = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   mem_port_arbiter_if.master bus
);
   localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
   logic [STV_W-1:0]   starve_cnt_q, starve_cnt_d;
   logic               owner_dm_q, owner_dm_d;
   logic               store_q, store_d;
   logic               any_req_s;
   logic               pick_if_s;

   // Arbitration, memory request mux and response steering
   always_comb begin
      state_d        = state_q;
      lat_cnt_d      = lat_cnt_q;
      starve_cnt_d   = starve_cnt_q;
      owner_dm_d     = owner_dm_q;
      store_d        = store_q;
      any_req_s      = 1'b0;
      pick_if_s      = 1'b0;
      bus.if_gnt     = 1'b0;
      bus.if_rvalid  = 1'b0;
      bus.if_rdata   = '0;
      bus.dm_gnt     = 1'b0;
      bus.dm_rvalid  = 1'b0;
      bus.dm_rdata   = '0;
      bus.mem_en     = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_size   = 2'b00;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      bus.busy       = (state_q == ST_WAIT);

      case (state_q)
         ST_IDLE: begin
            // Grants are gated by reset_n so nothing leaks out while reset is held
            any_req_s = reset_n & (bus.if_req | bus.dm_req);
            pick_if_s = bus.if_req & (~bus.dm_req | (starve_cnt_q == STV_MAX));
            if (any_req_s) begin
               bus.mem_en = 1'b1;
               lat_cnt_d  = LAT_INIT;
               state_d    = ST_WAIT;
               if (pick_if_s) begin
                  bus.if_gnt   = 1'b1;
                  bus.mem_size = 2'b10;
                  bus.mem_addr = bus.if_addr;
                  starve_cnt_d = '0;
                  owner_dm_d   = 1'b0;
                  store_d      = 1'b0;
               end else begin
                  bus.dm_gnt    = 1'b1;
                  bus.mem_we    = bus.dm_we;
                  bus.mem_size  = bus.dm_size;
                  bus.mem_addr  = bus.dm_addr;
                  bus.mem_wdata = bus.dm_we ? bus.dm_wdata : '0;
                  owner_dm_d    = 1'b1;
                  store_d       = bus.dm_we;
                  if (bus.if_req && (starve_cnt_q != STV_MAX)) begin
                     starve_cnt_d = starve_cnt_q + STV_W'(1);
                  end else begin
                     starve_cnt_d = starve_cnt_q;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (lat_cnt_q != '0) begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end else begin
               state_d = ST_IDLE;
               if (owner_dm_q) begin
                  bus.dm_rvalid = 1'b1;
                  bus.dm_rdata  = store_q ? '0 : bus.mem_rdata;
               end else begin
                  bus.if_rvalid = 1'b1;
                  bus.if_rdata  = bus.mem_rdata;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM and bookkeeping registers; reset drops any in-flight access
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         lat_cnt_q    <= '0;
         starve_cnt_q <= '0;
         owner_dm_q   <= 1'b0;
         store_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         owner_dm_q   <= owner_dm_d;
         store_q      <= store_d;
      end
   end
endmodule
